// File: rtl/sprite_anim_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_anim_seq_if
// Description : Control, pixel-request and ROM signals of the sprite
//               animation sequencer. The master side is the VGA path that
//               drives requests and returns ROM data; the slave side is the
//               sequencer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_anim_seq_if #(
    parameter int NFRAMES = 3,
    parameter int ADDR_W  = 12,
    parameter int PIX_W   = 12
);
    localparam int FRAME_W = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;

    logic                      en;
    logic [1:0]                mode;
    logic                      restart;
    logic                      vsync_start;
    logic [ADDR_W-1:0]         pix_addr;
    logic                      pix_addr_valid;
    logic [FRAME_W+ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]          rom_data;
    logic [PIX_W-1:0]          pix_out;
    logic                      pix_valid;
    logic [FRAME_W-1:0]        frame_idx;
    logic                      frame_tick;
    logic                      done;

    modport master (
        output en, mode, restart, vsync_start, pix_addr, pix_addr_valid, rom_data,
        input  rom_addr, pix_out, pix_valid, frame_idx, frame_tick, done
    );

    modport slave (
        input  en, mode, restart, vsync_start, pix_addr, pix_addr_valid, rom_data,
        output rom_addr, pix_out, pix_valid, frame_idx, frame_tick, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_anim_seq.sv
`default_nettype none
// ============================================================================
// Module      : sprite_anim_seq
// Description : Sprite animation sequencer. Steps a frame index through
//               NFRAMES frames (loop / ping-pong / one-shot / hold) at a
//               programmable rate, deferring every change to a vsync
//               boundary, and forms {frame, pixel} addresses into a packed
//               multi-frame sprite ROM with a valid-aligned pixel return.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_anim_seq #(
    parameter int NFRAMES = 3,
    parameter int ADDR_W  = 12,
    parameter int PIX_W   = 12,
    parameter int PERIOD  = 6000000,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sprite_anim_seq_if.slave  bus
);
    localparam int FRAME_W = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
    localparam int CNT_W   = $clog2(PERIOD);

    localparam logic [CNT_W-1:0]   c_CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [FRAME_W-1:0] c_LAST_IDX  = FRAME_W'(NFRAMES - 1);
    localparam logic [FRAME_W-1:0] c_IDX_ONE   = FRAME_W'(1);

    localparam logic [1:0] c_MODE_LOOP     = 2'b00;
    localparam logic [1:0] c_MODE_PINGPONG = 2'b01;
    localparam logic [1:0] c_MODE_ONESHOT  = 2'b10;

    // ---------------------------------------------------------------- state
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_pending;
    logic                      r_dir_down;
    logic                      r_done;
    logic                      r_tick;
    logic [FRAME_W-1:0]        r_idx;

    logic [FRAME_W+ADDR_W-1:0] r_rom_addr;
    logic [ROM_LAT:0]          r_vld_pipe;
    logic [PIX_W-1:0]          r_pix_out;
    logic                      r_pix_valid;

    // ----------------------------------------------------------- step logic
    logic                      w_wrap;
    logic                      w_apply;
    logic [FRAME_W-1:0]        w_next_idx;
    logic                      w_next_dir_down;
    logic                      w_done_set;
    logic                      w_step_tick;

    // A wrap coinciding with vsync applies at once; otherwise it is parked.
    assign w_wrap  = bus.en && (r_cnt == c_CNT_LAST);
    assign w_apply = bus.vsync_start && (r_pending || w_wrap);

    // Next frame index, direction and one-shot completion for the current mode.
    always_comb begin
        w_next_idx      = r_idx;
        w_next_dir_down = r_dir_down;
        w_done_set      = 1'b0;
        w_step_tick     = 1'b1;
        case (bus.mode)
            c_MODE_LOOP: begin
                w_next_idx = (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_ONE;
            end
            c_MODE_PINGPONG: begin
                // A single frame has nowhere to bounce to.
                if (NFRAMES > 1) begin
                    if (!r_dir_down) begin
                        if (r_idx == c_LAST_IDX) begin
                            w_next_dir_down = 1'b1;
                            w_next_idx      = r_idx - c_IDX_ONE;
                        end else begin
                            w_next_idx      = r_idx + c_IDX_ONE;
                        end
                    end else begin
                        if (r_idx == '0) begin
                            w_next_dir_down = 1'b0;
                            w_next_idx      = c_IDX_ONE;
                        end else begin
                            w_next_idx      = r_idx - c_IDX_ONE;
                        end
                    end
                end
            end
            c_MODE_ONESHOT: begin
                if (r_idx == c_LAST_IDX) begin
                    w_done_set = 1'b1;
                end else begin
                    w_next_idx = r_idx + c_IDX_ONE;
                end
            end
            default: begin
                // Hold: the pending step is swallowed silently.
                w_step_tick = 1'b0;
            end
        endcase
    end

    // Period counter, pending flag, frame index, direction and done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_dir_down <= 1'b0;
            r_done     <= 1'b0;
            r_tick     <= 1'b0;
            r_idx      <= '0;
        end else if (bus.restart) begin
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_dir_down <= 1'b0;
            r_done     <= 1'b0;
            r_tick     <= 1'b0;
            r_idx      <= '0;
        end else begin
            if (bus.en) begin
                r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            end

            // At most one step is ever outstanding.
            if (w_apply) begin
                r_pending <= 1'b0;
            end else if (w_wrap) begin
                r_pending <= 1'b1;
            end

            r_tick <= w_apply && w_step_tick;

            if (w_apply) begin
                r_idx <= w_next_idx;
            end

            if (bus.mode != c_MODE_PINGPONG) begin
                r_dir_down <= 1'b0;
            end else if (w_apply) begin
                r_dir_down <= w_next_dir_down;
            end

            if (bus.mode != c_MODE_ONESHOT) begin
                r_done <= 1'b0;
            end else if (w_apply && w_done_set) begin
                r_done <= 1'b1;
            end
        end
    end

    // Pixel path: register the ROM address and line the valid up with ROM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr  <= '0;
            r_vld_pipe  <= '0;
            r_pix_out   <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_rom_addr  <= {r_idx, bus.pix_addr};
            r_vld_pipe  <= {r_vld_pipe[ROM_LAT-1:0], bus.pix_addr_valid};
            r_pix_valid <= r_vld_pipe[ROM_LAT];
            r_pix_out   <= r_vld_pipe[ROM_LAT] ? bus.rom_data : '0;
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.pix_out    = r_pix_out;
    assign bus.pix_valid  = r_pix_valid;
    assign bus.frame_idx  = r_idx;
    assign bus.frame_tick = r_tick;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_anim_seq
// Description : Self-checking bench for sprite_anim_seq. Two instances
//               (3 frames / ROM latency 2 and 4 frames / ROM latency 1)
//               share stimulus; a frame-level reference model checks every
//               cycle, with directed tables and sequences on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_anim_seq;
    localparam int ADDR_W = 4;
    localparam int PIX_W  = 8;
    localparam int PERIOD = 4;
    localparam int NF_A   = 3;
    localparam int NF_B   = 4;
    localparam int LAT_A  = 2;
    localparam int LAT_B  = 1;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             en      = 1'b0;
    logic [1:0]       mode    = 2'b00;
    logic             restart = 1'b0;
    logic             vs      = 1'b0;
    logic [ADDR_W-1:0] pix_addr = '0;
    logic             pav     = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sprite_anim_seq_if #(.NFRAMES(NF_A), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus_a ();
    sprite_anim_seq_if #(.NFRAMES(NF_B), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus_b ();

    assign bus_a.en = en;             assign bus_b.en = en;
    assign bus_a.mode = mode;         assign bus_b.mode = mode;
    assign bus_a.restart = restart;   assign bus_b.restart = restart;
    assign bus_a.vsync_start = vs;    assign bus_b.vsync_start = vs;
    assign bus_a.pix_addr = pix_addr; assign bus_b.pix_addr = pix_addr;
    assign bus_a.pix_addr_valid = pav; assign bus_b.pix_addr_valid = pav;

    sprite_anim_seq #(.NFRAMES(NF_A), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
                      .PERIOD(PERIOD), .ROM_LAT(LAT_A))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    sprite_anim_seq #(.NFRAMES(NF_B), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
                      .PERIOD(PERIOD), .ROM_LAT(LAT_B))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Sprite ROMs: data is the address itself, returned after the ROM latency.
    logic [5:0] ra1 = '0, ra2 = '0, rb1 = '0;
    always @(posedge clk) begin
        ra1 <= bus_a.rom_addr;
        ra2 <= ra1;
        rb1 <= bus_b.rom_addr;
    end
    assign bus_a.rom_data = PIX_W'(ra2);
    assign bus_b.rom_data = PIX_W'(rb1);

    // ------------------------------------------------------ reference model
    typedef struct { bit v; int d; } pix_t;
    pix_t pq_a[$];
    pix_t pq_b[$];
    int   nf[2] = '{NF_A, NF_B};
    int   m_idx[2], m_cnt[2], m_dir[2], m_raddr[2], m_po[2];
    bit   m_pend[2], m_done[2], m_tick[2], m_pv[2];

    function automatic void model_reset(int k);
        m_idx[k] = 0; m_cnt[k] = 0; m_dir[k] = 1; m_pend[k] = 0;
        m_done[k] = 0; m_tick[k] = 0; m_raddr[k] = 0; m_pv[k] = 0; m_po[k] = 0;
    endfunction

    function automatic void model_step(int k);
        bit wrap, apply;
        m_tick[k] = 0;
        if (restart) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_pend[k] = 0; m_done[k] = 0; m_dir[k] = 1;
            return;
        end
        wrap  = en && (m_cnt[k] == PERIOD - 1);
        apply = vs && (m_pend[k] || wrap);
        if (en) m_cnt[k] = (m_cnt[k] + 1) % PERIOD;
        if (apply) begin
            m_pend[k] = 0;
            case (mode)
                2'd0: begin m_idx[k] = (m_idx[k] + 1) % nf[k]; m_tick[k] = 1; end
                2'd1: begin
                    if (nf[k] > 1) begin
                        if (m_idx[k] + m_dir[k] < 0 || m_idx[k] + m_dir[k] >= nf[k])
                            m_dir[k] = -m_dir[k];
                        m_idx[k] = m_idx[k] + m_dir[k];
                    end
                    m_tick[k] = 1;
                end
                2'd2: begin
                    if (m_idx[k] == nf[k] - 1) m_done[k] = 1;
                    else m_idx[k] = m_idx[k] + 1;
                    m_tick[k] = 1;
                end
                default: ;
            endcase
        end else if (wrap) begin
            m_pend[k] = 1;
        end
        if (mode != 2'd1) m_dir[k] = 1;
        if (mode != 2'd2) m_done[k] = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        pix_t e;
        if (!rst_n) begin
            model_reset(0); model_reset(1);
            pq_a.delete(); pq_b.delete();
        end else begin
            for (int k = 0; k < 2; k++) m_raddr[k] = m_idx[k] * (1 << ADDR_W) + int'(pix_addr);
            e.v = pav; e.d = pav ? m_raddr[0] : 0;
            pq_a.push_back(e);
            if (pq_a.size() > LAT_A + 2) void'(pq_a.pop_front());
            m_pv[0] = (pq_a.size() == LAT_A + 2) ? pq_a[0].v : 1'b0;
            m_po[0] = (pq_a.size() == LAT_A + 2) ? pq_a[0].d : 0;
            e.v = pav; e.d = pav ? m_raddr[1] : 0;
            pq_b.push_back(e);
            if (pq_b.size() > LAT_B + 2) void'(pq_b.pop_front());
            m_pv[1] = (pq_b.size() == LAT_B + 2) ? pq_b[0].v : 1'b0;
            m_po[1] = (pq_b.size() == LAT_B + 2) ? pq_b[0].d : 0;
            model_step(0); model_step(1);
        end
    end

    function automatic void chk_model(input int k, input logic [31:0] idx, tick, done,
                                      raddr, pv, po);
        tests++;
        if (idx !== 32'(m_idx[k]) || tick !== 32'(m_tick[k]) || done !== 32'(m_done[k]) ||
            raddr !== 32'(m_raddr[k]) || pv !== 32'(m_pv[k]) || po !== 32'(m_po[k])) begin
            fails++;
            $display("FAIL model dut%0d t=%0t got idx=%0d tick=%0d done=%0d raddr=%0d pv=%0d po=%0d want idx=%0d tick=%0d done=%0d raddr=%0d pv=%0d po=%0d",
                     k, $time, idx, tick, done, raddr, pv, po,
                     m_idx[k], m_tick[k], m_done[k], m_raddr[k], m_pv[k], m_po[k]);
        end
    endfunction

    // Every cycle, both instances are held against the model.
    always @(negedge clk) begin
        chk_model(0, 32'(bus_a.frame_idx), 32'(bus_a.frame_tick), 32'(bus_a.done),
                  32'(bus_a.rom_addr), 32'(bus_a.pix_valid), 32'(bus_a.pix_out));
        chk_model(1, 32'(bus_b.frame_idx), 32'(bus_b.frame_tick), 32'(bus_b.done),
                  32'(bus_b.rom_addr), 32'(bus_b.pix_valid), 32'(bus_b.pix_out));
    end

    // ------------------------------------------------------ directed helpers
    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_idx_a"},   32'(bus_a.frame_idx),  0);
        check({tag, "_tick_a"},  32'(bus_a.frame_tick), 0);
        check({tag, "_done_a"},  32'(bus_a.done),       0);
        check({tag, "_raddr_a"}, 32'(bus_a.rom_addr),   0);
        check({tag, "_pv_a"},    32'(bus_a.pix_valid),  0);
        check({tag, "_po_a"},    32'(bus_a.pix_out),    0);
        check({tag, "_idx_b"},   32'(bus_b.frame_idx),  0);
        check({tag, "_raddr_b"}, 32'(bus_b.rom_addr),   0);
    endtask

    typedef struct packed {
        logic       rst_first;
        logic [1:0] mode;
        logic [2:0] idx_a;
        logic       done_a;
        logic [2:0] idx_b;
        logic       done_b;
        logic       tick;
    } vec_t;

    vec_t tbl [0:18];

    initial begin
        // One record = one 4-cycle period with en and vsync high throughout.
        tbl = '{
            '{1'b1, 2'd0, 3'd1, 1'b0, 3'd1, 1'b0, 1'b1},
            '{1'b0, 2'd0, 3'd2, 1'b0, 3'd2, 1'b0, 1'b1},
            '{1'b0, 2'd0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1},
            '{1'b0, 2'd0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b1},
            '{1'b1, 2'd1, 3'd1, 1'b0, 3'd1, 1'b0, 1'b1},
            '{1'b0, 2'd1, 3'd2, 1'b0, 3'd2, 1'b0, 1'b1},
            '{1'b0, 2'd1, 3'd1, 1'b0, 3'd3, 1'b0, 1'b1},
            '{1'b0, 2'd1, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1},
            '{1'b0, 2'd1, 3'd1, 1'b0, 3'd1, 1'b0, 1'b1},
            '{1'b0, 2'd1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1},
            '{1'b0, 2'd1, 3'd1, 1'b0, 3'd1, 1'b0, 1'b1},
            '{1'b1, 2'd2, 3'd1, 1'b0, 3'd1, 1'b0, 1'b1},
            '{1'b0, 2'd2, 3'd2, 1'b0, 3'd2, 1'b0, 1'b1},
            '{1'b0, 2'd2, 3'd2, 1'b1, 3'd3, 1'b0, 1'b1},
            '{1'b0, 2'd2, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1},
            '{1'b0, 2'd2, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1},
            '{1'b0, 2'd2, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1},
            '{1'b0, 2'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1},
            '{1'b0, 2'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}
        };

        // Reset state.
        repeat (2) cyc();
        check_zero("reset");
        #1 rst_n = 1'b1;

        // Table: loop, ping-pong, one-shot, back to loop, hold.
        for (int r = 0; r < 19; r++) begin
            if (tbl[r].rst_first) begin
                restart = 1'b1; en = 1'b1; vs = 1'b1; mode = tbl[r].mode;
                cyc();
                restart = 1'b0;
            end
            mode = tbl[r].mode; en = 1'b1; vs = 1'b1;
            repeat (4) cyc();
            check($sformatf("tbl%0d_idx_a", r),  32'(bus_a.frame_idx),  32'(tbl[r].idx_a));
            check($sformatf("tbl%0d_done_a", r), 32'(bus_a.done),       32'(tbl[r].done_a));
            check($sformatf("tbl%0d_tick_a", r), 32'(bus_a.frame_tick), 32'(tbl[r].tick));
            check($sformatf("tbl%0d_idx_b", r),  32'(bus_b.frame_idx),  32'(tbl[r].idx_b));
            check($sformatf("tbl%0d_done_b", r), 32'(bus_b.done),       32'(tbl[r].done_b));
            check($sformatf("tbl%0d_tick_b", r), 32'(bus_b.frame_tick), 32'(tbl[r].tick));
        end

        // Vsync deferral: sparse vsync, then en dropped with a step pending.
        restart = 1'b1; en = 1'b1; vs = 1'b0; mode = 2'd0;
        cyc();
        restart = 1'b0;
        for (int i = 1; i <= 55; i++) begin
            en = (i <= 44);
            vs = (i % 10 == 0);
            cyc();
            check($sformatf("defer_tick_%0d", i), 32'(bus_a.frame_tick), 32'(i % 10 == 0));
        end
        vs = 1'b0;
        check("defer_idx_a", 32'(bus_a.frame_idx), 2);
        check("defer_idx_b", 32'(bus_b.frame_idx), 1);

        // Restart collides with wrap + vsync at idx 2.
        restart = 1'b1; en = 1'b1; vs = 1'b1; mode = 2'd0;
        cyc();
        restart = 1'b0;
        repeat (8) cyc();
        check("rst_pre_idx_a", 32'(bus_a.frame_idx), 2);
        vs = 1'b0;
        repeat (3) cyc();
        restart = 1'b1; vs = 1'b1;
        cyc();
        restart = 1'b0;
        check("rst_idx_a",  32'(bus_a.frame_idx),  0);
        check("rst_tick_a", 32'(bus_a.frame_tick), 0);
        check("rst_idx_b",  32'(bus_b.frame_idx),  0);
        for (int n = 1; n <= 4; n++) begin
            cyc();
            check($sformatf("rst_cnt_tick_%0d", n), 32'(bus_a.frame_tick), 32'(n == 4));
        end
        check("rst_post_idx_a", 32'(bus_a.frame_idx), 1);

        // Pixel path: three requests at frame 1, then idle.
        en = 1'b0; vs = 1'b0; mode = 2'd3;
        for (int j = 1; j <= 8; j++) begin
            pav      = (j <= 3);
            pix_addr = (j <= 3) ? ADDR_W'(j + 4) : ADDR_W'(9);
            cyc();
            check($sformatf("pix_raddr_a_%0d", j), 32'(bus_a.rom_addr), 32'(16 + int'(pix_addr)));
            check($sformatf("pix_pv_a_%0d", j), 32'(bus_a.pix_valid), 32'(j >= 4 && j <= 6));
            check($sformatf("pix_po_a_%0d", j), 32'(bus_a.pix_out),
                  (j >= 4 && j <= 6) ? 32'(16 + j + 1) : 32'd0);
            check($sformatf("pix_pv_b_%0d", j), 32'(bus_b.pix_valid), 32'(j >= 3 && j <= 5));
            check($sformatf("pix_po_b_%0d", j), 32'(bus_b.pix_out),
                  (j >= 3 && j <= 5) ? 32'(16 + j + 2) : 32'd0);
        end

        // Randomised traffic against the model, with an async reset mid-run.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1 check_zero("midrst");
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            restart  = ($urandom_range(0, 99) == 0);
            en       = ($urandom_range(0, 7) != 0);
            vs       = ($urandom_range(0, 3) == 0);
            pav      = $urandom_range(0, 1) == 1;
            pix_addr = ADDR_W'($urandom_range(0, 15));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sprite_anim_seq.md
# sprite_anim_seq

Parametrised sprite animation sequencer for the VGA sprite path. It steps a frame index through `NFRAMES` animation frames at a programmable rate, with loop, ping-pong, one-shot and hold modes. Frame changes are deferred to the next vertical-sync boundary so a sprite never tears mid-screen. The block forms a combined address into a single packed multi-frame sprite ROM and returns the pixel aligned with a valid strobe. It sits between the pixel-address generator and the VGA colour mux, and supersedes the fixed three-ROM frame selector.

## Interface
- `NFRAMES`, default 3: number of animation frames; must be ≥ 1.
- `ADDR_W`, default 12: per-frame pixel address width.
- `PIX_W`, default 12: pixel width (RGB444).
- `PERIOD`, default 6000000: clk cycles per animation step; must be ≥ 2.
- `ROM_LAT`, default 1: ROM read latency in cycles; must be ≥ 1.
- Derived: `FRAME_W = max(1, clog2(NFRAMES))`; `CNT_W = clog2(PERIOD)`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  period counter runs when high.
- `mode`  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 hold.
- `restart`  in  1  synchronous restart pulse.
- `vsync_start`  in  1  one-cycle pulse at the start of each VGA frame.
- `pix_addr`  in  ADDR_W  pixel address within the sprite.
- `pix_addr_valid`  in  1  `pix_addr` is a sprite pixel.
- `rom_addr`  out  FRAME_W+ADDR_W  registered `{frame_idx, pix_addr}`.
- `rom_data`  in  PIX_W  ROM output, ROM_LAT cycles after `rom_addr`.
- `pix_out`  out  PIX_W  registered pixel.
- `pix_valid`  out  1  `pix_out` is valid.
- `frame_idx`  out  FRAME_W  current frame.
- `frame_tick`  out  1  one-cycle pulse when a step is applied.
- `done`  out  1  one-shot has reached the last frame.

## Operation
- **Reset.** All registers and outputs are 0, including `frame_idx`, `pix_out`, `pix_valid`, `rom_addr`, `done` and `frame_tick`. Direction is up and `pending` is 0.
- **Period counter.**
  - Increments when `en` is high; holds when `en` is low.
  - At `PERIOD-1` it wraps to 0 and sets `pending`.
  - A wrap while `pending` is already set does not accumulate; at most one step is ever pending.
- **Applying a step.** On `vsync_start` with (`pending` or wrap this cycle):
  - The step is applied, `pending` clears and `frame_tick` pulses.
  - `en` low does not block a pending step.
  - `vsync_start` without a pending step does nothing.
- **Step rules by mode:**
  - Loop: `idx = (idx == NFRAMES-1) ? 0 : idx+1`.
  - Ping-pong:
    - Moving up, at `NFRAMES-1`: flip direction and go to `idx-1`.
    - Moving down, at 0: flip direction and go to 1.
    - `NFRAMES=1`: stay at 0.
  - One-shot: increment until `NFRAMES-1`. A step applied at `NFRAMES-1` sets `done`, and `done` stays set. Further steps leave `idx` unchanged, but `frame_tick` still pulses.
  - Hold: `idx` is unchanged, `pending` is discarded, and `frame_tick` does not pulse.
- **Mode changes.**
  - A new `mode` takes effect at the next applied step.
  - Whenever `mode != 01`, direction is forced to up.
  - Leaving one-shot clears `done`.
- **Restart.**
  - `restart` has the highest priority over step, wrap and `vsync_start`.
  - Next cycle: `idx = 0`, counter = 0, `pending = 0`, `done = 0`, direction up, `frame_tick = 0`.
  - The pixel pipeline is not flushed.
- **Pixel path.**
  - `rom_addr` registers the current `frame_idx` concatenated with `pix_addr` every cycle.
  - `pix_out <= delayed_valid ? rom_data : 0`.

## Timing
- A pixel request at cycle t (`pix_addr_valid=1`) gives `pix_out`/`pix_valid` at cycle t+2+ROM_LAT. With the default `ROM_LAT=1` that is 3 cycles; the pipeline is fully pipelined, one pixel per clk.
- `pix_valid` is `pix_addr_valid` delayed by 2+ROM_LAT cycles. Invalid slots output `pix_out = 0`.
- `frame_idx` changes in the cycle after the qualifying `vsync_start`. Addresses registered from that cycle onward use the new frame.
- `frame_tick` is high in the same cycle `frame_idx` shows the new value.
- Wrap and `vsync_start` in the same cycle apply the step immediately.
- Steady rate with `en` high: one step per PERIOD cycles, quantised to the first `vsync_start` at or after each wrap.

## Test plan
- **Loop.** NFRAMES=3, PERIOD=4, `vsync_start` every cycle, mode 00 → `frame_idx` 0,1,2,0,1 at 4-cycle spacing; `frame_tick` pulses each change.
- **Ping-pong.** NFRAMES=4, mode 01 → index sequence 0,1,2,3,2,1,0,1.
- **One-shot.** NFRAMES=3, mode 10 → 0,1,2. `done` rises at the step applied at idx 2 and stays high over 3 further periods, with idx held at 2. Switching to mode 00 clears `done`.
- **Vsync deferral.** PERIOD=4, `vsync_start` every 10 cycles → exactly one step per vsync, no catch-up steps. Dropping `en` low with a step pending → the step still applies at the next vsync.
- **Restart priority.** `restart` asserted in the same cycle as a wrap plus `vsync_start` at idx 2 → next cycle idx=0, counter=0, `frame_tick=0`. Reset mid-run via `rst_n` low → all outputs 0 immediately.
- **Pixel path.** ROM model with data = `{frame, addr}` low bits and ROM_LAT=2. `pix_addr` 5,6,7 with `pix_addr_valid` high, then low → `pix_valid` high exactly 4 cycles later for 3 cycles, data matching frame and address, then `pix_out=0`.
